// File: rtl/mem_io_bridge.sv
// Data-port bridge for the single-cycle miniRV core: splits accesses between data RAM
// and the LED / seven-segment / switch / button peripherals, answering loads combinationally.
module mem_io_bridge #(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdin,
  output logic [31:0] rdata,
  output logic [13:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  localparam logic [11:0] OFF_DISP = 12'h000;
  localparam logic [11:0] OFF_LED  = 12'h060;
  localparam logic [11:0] OFF_SW   = 12'h070;
  localparam logic [11:0] OFF_BTN  = 12'h078;

  logic             w_periph;
  logic             w_hit_disp;
  logic             w_hit_led;
  logic [3:0]       w_nibble;

  logic [31:0]      r_disp;
  logic [23:0]      r_led;
  logic [23:0]      r_sw_meta;
  logic [23:0]      r_sw_s;
  logic [4:0]       r_btn_meta;
  logic [4:0]       r_btn_s;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_idx;

  assign w_periph   = (addr[31:12] == 20'hFFFFF);
  assign w_hit_disp = w_periph && (addr[11:0] == OFF_DISP);
  assign w_hit_led  = w_periph && (addr[11:0] == OFF_LED);

  assign ram_a  = addr[15:2];
  assign ram_we = we & ~w_periph;
  assign ram_wd = wdin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp     <= '0;
      r_led      <= '0;
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_btn_meta <= '0;
      r_btn_s    <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else begin
      if (we && w_hit_disp) r_disp <= wdin;
      if (we && w_hit_led)  r_led  <= wdin[23:0];
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
      r_btn_meta <= btn;
      r_btn_s    <= r_btn_meta;
      // Free-running digit scan: each digit dwells exactly SCAN_DIV cycles.
      if (r_scan_cnt == CNT_LAST) begin
        r_scan_cnt <= '0;
        r_idx      <= r_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rdata = ram_rd;
    if (w_periph) begin
      case (addr[11:0])
        OFF_DISP: rdata = r_disp;
        OFF_LED:  rdata = {8'h0, r_led};
        OFF_SW:   rdata = {8'h0, r_sw_s};
        OFF_BTN:  rdata = {27'h0, r_btn_s};
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign led      = r_led;
  assign dig_en   = ~(8'b1 << r_idx);
  assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

  // Active-low hex font; bit 7 (DP) stays high in every entry.
  always_comb begin
    seg = 8'hFF;
    case (w_nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic against a cycle-count based reference model.
module tb_mem_io_bridge;

  localparam int TB_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdin;
  logic [31:0] rdata;
  logic [13:0] ram_a;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;
  logic [23:0] sw;
  logic [4:0]  btn;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  mem_io_bridge #(.SCAN_DIV(TB_DIV)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdin(wdin), .rdata(rdata),
    .ram_a(ram_a), .ram_we(ram_we), .ram_wd(ram_wd), .ram_rd(ram_rd),
    .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: registers plus the number of edges since the last reset.
  logic [31:0] m_disp;
  logic [23:0] m_led;
  int          m_cyc;
  bit          m_valid = 1'b0;
  logic [23:0] sw_hist[$];
  logic [4:0]  btn_hist[$];

  logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0]  scan_segs [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
  logic [11:0] offs [6] = '{12'h000, 12'h060, 12'h070, 12'h078, 12'h004, 12'h100};

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdin;
    logic [31:0] ram_rd;
    logic [31:0] exp_rdata;
    logic        exp_ram_we;
    logic [13:0] exp_ram_a;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_rdata;
    int          d;
    logic [3:0]  nib;
    if (m_valid) begin
      e_rdata = ram_rd;
      if (addr[31:12] == 20'hFFFFF) begin
        case (addr[11:0])
          12'h000: e_rdata = m_disp;
          12'h060: e_rdata = {8'h0, m_led};
          12'h070: e_rdata = {8'h0, sw_hist[sw_hist.size() - 2]};
          12'h078: e_rdata = {27'h0, btn_hist[btn_hist.size() - 2]};
          default: e_rdata = 32'h0;
        endcase
      end
      d   = (m_cyc / TB_DIV) % 8;
      nib = 4'((m_disp >> (4 * d)) & 32'hF);
      check("model rdata", rdata, e_rdata);
      check("model ram_a", {18'h0, ram_a}, {18'h0, addr[15:2]});
      check("model ram_we", {31'h0, ram_we}, {31'h0, we & (addr[31:12] != 20'hFFFFF)});
      check("model ram_wd", ram_wd, wdin);
      check("model led", {8'h0, led}, {8'h0, m_led});
      check("model dig_en", {24'h0, dig_en}, {24'h0, ~(8'h01 << d)});
      check("model seg", {24'h0, seg}, {24'h0, seg_tab[nib]});
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_disp = '0;
      m_led  = '0;
      m_cyc  = 0;
      sw_hist.delete();
      btn_hist.delete();
      sw_hist.push_back(24'h0);
      sw_hist.push_back(24'h0);
      btn_hist.push_back(5'h0);
      btn_hist.push_back(5'h0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (we && addr == 32'hFFFFF000) m_disp = wdin;
      if (we && addr == 32'hFFFFF060) m_led = wdin[23:0];
      sw_hist.push_back(sw);
      btn_hist.push_back(btn);
      if (sw_hist.size() > 4) void'(sw_hist.pop_front());
      if (btn_hist.size() > 4) void'(btn_hist.pop_front());
      m_cyc++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    edge_step();
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a;
    we   = w;
    wdin = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h00000104, 1'b1, 32'hDEADBEEF, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 14'h041};
    vecs[1]  = '{32'h00000104, 1'b0, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 14'h041};
    vecs[2]  = '{32'hFFFFF000, 1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 14'h3C00};
    vecs[3]  = '{32'hFFFFF060, 1'b0, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 14'h3C18};
    vecs[4]  = '{32'hFFFFF070, 1'b1, 32'hFFFFFFFF, 32'h55555555, 32'h00000000, 1'b0, 14'h3C1C};
    vecs[5]  = '{32'hFFFFF078, 1'b1, 32'hFFFFFFFF, 32'h55555555, 32'h00000000, 1'b0, 14'h3C1E};
    vecs[6]  = '{32'hFFFFF100, 1'b1, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h00000000, 1'b0, 14'h3C40};
    vecs[7]  = '{32'hFFFFF064, 1'b0, 32'h00000000, 32'hAAAAAAAA, 32'h00000000, 1'b0, 14'h3C19};
    vecs[8]  = '{32'hFFFFE000, 1'b1, 32'hCAFEF00D, 32'h13579BDF, 32'h13579BDF, 1'b1, 14'h3800};
    vecs[9]  = '{32'h7FFFF060, 1'b1, 32'h00C0FFEE, 32'h2468ACE0, 32'h2468ACE0, 1'b1, 14'h3C18};
    vecs[10] = '{32'hFFFFF070, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 14'h3C1C};

    // Reset with random switches and buttons.
    rst = 1'b1;
    drive(32'h0, 1'b0, 32'h0);
    ram_rd = 32'h0;
    sw  = 24'($urandom);
    btn = 5'($urandom);
    tick();
    tick();
    rst = 1'b0;
    sw  = 24'h0;
    btn = 5'h0;
    drive(32'hFFFFF000, 1'b0, 32'h0);
    settle();
    check("reset led", {8'h0, led}, 32'h0);
    check("reset dig_en", {24'h0, dig_en}, 32'hFE);
    check("reset seg", {24'h0, seg}, 32'hC0);
    check("reset rdata disp", rdata, 32'h0);
    edge_step();

    // Combinational decode table.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wdin);
      ram_rd = vecs[i].ram_rd;
      settle();
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d ram_we", i), {31'h0, ram_we}, {31'h0, vecs[i].exp_ram_we});
      check($sformatf("vec%0d ram_a", i), {18'h0, ram_a}, {18'h0, vecs[i].exp_ram_a});
      edge_step();
    end

    // LED store: same-cycle load sees the old value, next cycle the new one.
    drive(32'hFFFFF060, 1'b1, 32'hAB123456);
    settle();
    check("led store ram_we", {31'h0, ram_we}, 32'h0);
    check("led same-cycle rdata", rdata, 32'h0);
    edge_step();
    drive(32'hFFFFF060, 1'b0, 32'h0);
    settle();
    check("led value", {8'h0, led}, 32'h00123456);
    check("led rdata", rdata, 32'h00123456);
    edge_step();

    // Switch and button synchroniser latency.
    drive(32'hFFFFF070, 1'b0, 32'h0);
    sw = 24'h00A5A5;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("sw sync edge%0d", k), rdata, (k < 2) ? 32'h0 : 32'h0000A5A5);
      edge_step();
    end
    drive(32'hFFFFF078, 1'b0, 32'h0);
    btn = 5'h13;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("btn sync edge%0d", k), rdata, (k < 2) ? 32'h0 : 32'h00000013);
      edge_step();
    end

    // Reset coinciding with a store wins.
    rst = 1'b1;
    drive(32'hFFFFF060, 1'b1, 32'h00FFFFFF);
    tick();
    rst = 1'b0;
    drive(32'hFFFFF060, 1'b0, 32'h0);
    settle();
    check("reset over store led", {8'h0, led}, 32'h0);
    check("reset over store rdata", rdata, 32'h0);
    edge_step();

    // Display scan from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(32'hFFFFF000, 1'b1, 32'h89ABCDEF);
    tick();
    drive(32'hFFFFF000, 1'b0, 32'h0);
    for (int k = 1; k <= 33; k++) begin
      settle();
      check($sformatf("scan dig_en c%0d", k), {24'h0, dig_en}, {24'h0, ~(8'h01 << ((k / 4) % 8))});
      check($sformatf("scan seg c%0d", k), {24'h0, seg}, {24'h0, scan_segs[(k / 4) % 8]});
      edge_step();
    end

    // Unmapped and read-only stores leave state alone.
    drive(32'hFFFFF100, 1'b1, 32'hFFFFFFFF);
    settle();
    check("unmapped store ram_we", {31'h0, ram_we}, 32'h0);
    edge_step();
    drive(32'hFFFFF070, 1'b1, 32'h00000000);
    settle();
    check("sw store ram_we", {31'h0, ram_we}, 32'h0);
    edge_step();
    drive(32'hFFFFF000, 1'b0, 32'h0);
    settle();
    check("disp after dropped stores", rdata, 32'h89ABCDEF);
    edge_step();
    drive(32'hFFFFF100, 1'b0, 32'h0);
    settle();
    check("unmapped load", rdata, 32'h0);
    edge_step();

    // Random traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        a = {20'hFFFFF, offs[sel]};
      end else if (sel == 6) begin
        a = {20'hFFFFF, 12'($urandom)};
      end else begin
        a = $urandom;
        if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
      end
      drive(a, 1'($urandom_range(0, 1)), $urandom);
      ram_rd = $urandom;
      if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
# mem_io_bridge

Memory-mapped bus bridge directly downstream of the single-cycle miniRV core's data port. Decodes the core's data address, steers accesses to the data RAM or to on-board peripherals, and returns read data in the same cycle, as the single-cycle core requires. Owns the peripheral state:

- LED register
- 8-digit seven-segment display register and its scan logic
- synchronisers for switches and buttons

## Interface

Parameters:
- SCAN_DIV, default 20000: clock cycles each display digit stays lit; legal range 1..2^20.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- addr  in  32  byte address from core (dram_addr).
- we  in  1  store strobe from core (dram_we).
- wdin  in  32  store data from core (dram_wdin).
- rdata  out  32  load data to core (dram_rd).
- ram_a  out  14  data RAM word address = addr[15:2].
- ram_we  out  1  data RAM write enable.
- ram_wd  out  32  data RAM write data = wdin.
- ram_rd  in  32  data RAM read data (combinational RAM).
- sw  in  24  raw switches (asynchronous).
- btn  in  5  raw buttons (asynchronous).
- led  out  24  LED drive, active-high.
- dig_en  out  8  digit enables, active-low, bit i = digit i.
- seg  out  8  segments, active-low, {DP,g,f,e,d,c,b,a}.

## Operation

Address decode:
- Peripheral space when addr[31:12] == 20'hFFFFF. Everything else is RAM.
- Peripheral offsets (addr[11:0]):
  - 0x000: DISP, read/write, 32 bits.
  - 0x060: LED, read/write, low 24 bits.
  - 0x070: SW, read-only.
  - 0x078: BTN, read-only.
- Other peripheral offsets read 0; writes to them are dropped.
- ram_we = we & ~peripheral. RAM never sees peripheral stores.

Read mux (combinational):
- RAM: ram_rd.
- DISP: disp_reg.
- LED: {8'h0, led}.
- SW: {8'h0, sw_s}.
- BTN: {27'h0, btn_s}.

Writes:
- A DISP or LED hit with we=1 loads wdin (LED: wdin[23:0]) at that rising edge.
- Writes to SW or BTN are ignored.

Synchronisers:
- sw and btn each pass through two flops.
- sw_s and btn_s are the second stage.

Display scan:
- scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
- On each wrap, digit index idx (3 bits) increments, wrapping 7 to 0.
- Scan is free-running and independent of bus traffic.

Display outputs (combinational from registers):
- dig_en = ~(8'b1 << idx).
- seg[7] = 1 (DP always off).
- seg[6:0] decodes nibble disp_reg[4*idx+3:4*idx] as hex, full seg value:
  - 0:C0, 1:F9, 2:A4, 3:B0
  - 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83
  - C:C6, d:A1, E:86, F:8E

## Timing

- Reset (rst high at an edge) clears:
  - disp_reg, led, scan_cnt, idx
  - both synchroniser stages
- Outputs after reset:
  - led = 0
  - dig_en = 8'hFE
  - seg = 8'hC0
  - rdata follows the decode of the current addr.
- Reset asserted mid-scan or mid-store wins over the store and the counter increment. No partial update.
- rdata, ram_a, ram_we, ram_wd have zero latency; they are combinational from addr, we, wdin.
- Store to LED/DISP:
  - Register changes at the edge where we=1.
  - led and seg reflect the new value in the following cycle.
  - A same-cycle load of the same address returns the old value.
- Switch/button change reaches rdata after 2 rising edges (up to 3 cycles from an asynchronous change).
- Digit dwell is exactly SCAN_DIV cycles.
  - SCAN_DIV=1: idx advances every cycle.
  - Full refresh period = 8*SCAN_DIV cycles.
- A DISP write landing on the same edge as an idx advance: the new idx and the new value both apply in the next cycle.

## Test plan

1. Reset: hold rst 2 cycles with random sw/btn -> led=0, dig_en=FE, seg=C0; load from 0xFFFFF000 returns 0.
2. RAM path: store 0xDEADBEEF to addr 0x00000104 -> ram_we=1, ram_a=0x041, ram_wd=0xDEADBEEF. Load with ram_rd=0x12345678 -> rdata=0x12345678 same cycle.
3. LED: store 0xAB123456 to 0xFFFFF060 -> ram_we=0; next cycle led=0x123456; load 0xFFFFF060 -> 0x00123456.
4. Switch sync: sw changes 0 -> 0x00A5A5 -> load 0xFFFFF070 returns 0 for 2 edges, then 0x0000A5A5. Same check for btn=5'h13 -> 0x13.
5. Display scan, SCAN_DIV=4: store 0x89ABCDEF to DISP -> digits 0..7 show seg 8E,86,A1,C6,83,88,90,80. Each digit lasts 4 cycles with matching dig_en FE,FD,...,7F, then wraps to FE.
6. Unmapped and read-only: store to 0xFFFFF070 and 0xFFFFF100 -> ram_we=0, no register change; load 0xFFFFF100 -> 0.
